// File: rtl/uart_tx_arbiter_if.sv
// Purpose : requester byte lanes plus the uart_send handshake, bundled for uart_tx_arbiter.
// Latency : n/a (wires only).
// Backpressure: req_ready is the per-lane ready; tx_busy paces the transmitter side.
// Ports (signals):
//   req_valid/req_data/req_last -> per-lane byte streams into the arbiter
//   req_ready                   <- per-lane accept, combinational from the arbiter state
//   tx_en/tx_data               <- start pulse and byte to uart_send
//   tx_busy                     -> uart_send shifting a frame
//   grant_valid/grant_id        <- packet grant status
//   timeout_err                 <- one-cycle pulse when a stalled grant is revoked
// Modports: slave = the arbiter, master = the surrounding environment.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic               tx_en;
   logic [7:0]         tx_data;
   logic               tx_busy;
   logic               grant_valid;
   logic [ID_W-1:0]    grant_id;
   logic               timeout_err;

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_en, tx_data, grant_valid, grant_id, timeout_err
   );

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_en, tx_data, grant_valid, grant_id, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose : shares one uart_send between N_REQ byte-stream requesters, one packet per grant, round-robin.
// Latency : request seen in IDLE at t -> grant at t+1 -> byte accepted at t+1 -> tx_en at t+2.
// Backpressure: only the granted lane sees req_ready, and only while SEND; bytes are paced by tx_busy.
// Ports:
//   sys_clk  - system clock, rising edge
//   sys_rst  - synchronous active-high reset
//   bus      - uart_tx_arbiter_if.slave: request lanes, uart_send handshake, grant/timeout status
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int              TW       = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0]   TMO_MAX  = {TW{1'b1}};
   localparam logic [ID_W-1:0] ID_MAX   = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic             grant_valid_q, grant_valid_d;
   logic             tx_en_q, tx_en_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             timeout_err_q, timeout_err_d;
   logic             last_q, last_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;

   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W-1:0]  cand;
   logic [ID_W-1:0]  ptr_after;
   logic [N_REQ-1:0] req_ready_w;
   logic             xfer;
   logic [7:0]       lane_byte;

   // Round-robin search: first valid lane starting at ptr, wrapping modulo N_REQ.
   always_comb begin : arb
      win_found = 1'b0;
      win_id    = ptr_q;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // The requester just served drops to lowest priority.
   assign ptr_after = (grant_id_q == ID_MAX) ? '0 : grant_id_q + 1'b1;

   always_comb begin : rdy
      req_ready_w = '0;
      if (state_q == SEND) begin
         req_ready_w[grant_id_q] = 1'b1;
      end
   end

   assign xfer      = bus.req_valid[grant_id_q];
   assign lane_byte = bus.req_data[{grant_id_q, 3'b000} +: 8];

   always_comb begin : fsm
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      tx_en_d       = 1'b0;
      tx_data_d     = tx_data_q;
      timeout_err_d = 1'b0;
      last_d        = last_q;
      tmo_cnt_d     = tmo_cnt_q;
      case (state_q)
         IDLE: begin
            // A frame still on the line (e.g. after reset) blocks arbitration.
            if (!bus.tx_busy && win_found) begin
               grant_id_d    = win_id;
               grant_valid_d = 1'b1;
               tmo_cnt_d     = '0;
               state_d       = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               tx_data_d = lane_byte;
               last_d    = bus.req_last[grant_id_q];
               tx_en_d   = 1'b1;
               state_d   = WAIT_BUSY;
            end else if (tmo_cnt_q >= TMO_LAST) begin
               timeout_err_d = 1'b1;
               grant_valid_d = 1'b0;
               ptr_d         = ptr_after;
               state_d       = IDLE;
            end else if (tmo_cnt_q != TMO_MAX) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (!bus.tx_busy) begin
               if (last_q) begin
                  grant_valid_d = 1'b0;
                  ptr_d         = ptr_after;
                  state_d       = IDLE;
               end else begin
                  tmo_cnt_d = '0;
                  state_d   = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         tx_en_q       <= 1'b0;
         tx_data_q     <= '0;
         timeout_err_q <= 1'b0;
         last_q        <= 1'b0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         tx_en_q       <= tx_en_d;
         tx_data_q     <= tx_data_d;
         timeout_err_q <= timeout_err_d;
         last_q        <= last_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign bus.req_ready   = req_ready_w;
   assign bus.tx_en       = tx_en_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter with a packet-level requester/uart model.
// Latency : n/a.
// Backpressure: lanes pop a byte only on valid & ready; tx_busy held 10 cycles per tx_en.
module tb_uart_tx_arbiter;
   localparam int N        = 4;
   localparam int TMO      = 16;
   localparam int BUSY_CYC = 10;

   logic clk;
   logic sys_rst;

   uart_tx_arbiter_if #(.N_REQ(N), .ID_W(2)) bus();

   uart_tx_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- requesters and uart_send model ----------------
   logic [8:0] lane_q [N][$];  // {last, byte}
   int         busy_left = 0;
   logic [N-1:0] hs;
   logic         ten;

   initial begin : drv
      logic [N-1:0]   v, l;
      logic [8*N-1:0] d;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.tx_busy   = 1'b0;
      forever begin
         @(negedge clk);
         hs  = bus.req_valid & bus.req_ready;
         ten = bus.tx_en;
         @(posedge clk);
         #1;
         v = '0; l = '0; d = '0;
         for (int i = 0; i < N; i++) begin
            if (hs[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            if (lane_q[i].size() > 0) begin
               v[i]         = 1'b1;
               l[i]         = lane_q[i][0][8];
               d[8*i +: 8]  = lane_q[i][0][7:0];
            end
         end
         bus.req_valid = v;
         bus.req_last  = l;
         bus.req_data  = d;
         if (ten) busy_left = BUSY_CYC;
         else if (busy_left > 0) busy_left--;
         bus.tx_busy = (busy_left > 0);
      end
   end

   // ---------------- reference model ----------------
   // holder: granted lane or -1; phase: 0 awaiting byte, 1 byte issued awaiting busy, 2 awaiting busy fall.
   int         m_holder = -1, m_phase = 0, m_start = 0, m_gid = 0, m_cnt = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_last = 1'b0;
   logic       exp_ten = 1'b0, exp_tmo = 1'b0;

   task automatic model_step();
      logic [N-1:0] v;
      v       = bus.req_valid;
      exp_ten = 1'b0;
      exp_tmo = 1'b0;
      if (sys_rst) begin
         m_holder = -1; m_phase = 0; m_start = 0; m_gid = 0; m_cnt = 0;
         m_data = 8'h00; m_last = 1'b0;
      end else if (m_holder < 0) begin
         if (!bus.tx_busy && v != '0) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_start + k) % N;
               if (m_holder < 0 && v[c]) m_holder = c;
            end
            m_gid = m_holder; m_phase = 0; m_cnt = 0;
         end
      end else if (m_phase == 0) begin
         if (v[m_holder]) begin
            m_data  = bus.req_data[8*m_holder +: 8];
            m_last  = bus.req_last[m_holder];
            exp_ten = 1'b1;
            m_phase = 1;
         end else if (m_cnt == TMO - 1) begin
            exp_tmo  = 1'b1;
            m_start  = (m_holder + 1) % N;
            m_holder = -1;
         end else begin
            m_cnt++;
         end
      end else if (m_phase == 1) begin
         if (bus.tx_busy) m_phase = 2;
      end else begin
         if (!bus.tx_busy) begin
            if (m_last) begin
               m_start  = (m_holder + 1) % N;
               m_holder = -1;
            end else begin
               m_phase = 0;
               m_cnt   = 0;
            end
         end
      end
   endtask

   // ---------------- compare process + event logs ----------------
   int         cyc = 0;
   int         glog[$];
   logic [7:0] txlog[$];
   int         tmo_n = 0, tmo_cyc = 0, send_cyc = 0, gv_fall_cyc = 0, busy_fall_cyc = 0;
   logic       gv_prev = 1'b0, rdy_prev = 1'b0, busy_prev = 1'b0;

   initial begin : mon
      logic [N-1:0] exp_rdy;
      forever begin
         @(negedge clk);
         cyc++;
         exp_rdy = (m_holder >= 0 && m_phase == 0) ? (N'(1) << m_holder) : '0;
         check("req_ready",   32'(bus.req_ready),   32'(exp_rdy));
         check("grant_valid", 32'(bus.grant_valid), 32'(m_holder >= 0));
         check("grant_id",    32'(bus.grant_id),    32'(m_gid));
         check("tx_en",       32'(bus.tx_en),       32'(exp_ten));
         check("tx_data",     32'(bus.tx_data),     32'(m_data));
         check("timeout_err", 32'(bus.timeout_err), 32'(exp_tmo));
         if (bus.grant_valid && !gv_prev) glog.push_back(int'(bus.grant_id));
         if (!bus.grant_valid && gv_prev) gv_fall_cyc = cyc;
         if (bus.tx_en) txlog.push_back(bus.tx_data);
         if (bus.timeout_err) begin tmo_n++; tmo_cyc = cyc; end
         if ((|bus.req_ready) && !rdy_prev) send_cyc = cyc;
         if (!bus.tx_busy && busy_prev) busy_fall_cyc = cyc;
         gv_prev   = bus.grant_valid;
         rdy_prev  = |bus.req_ready;
         busy_prev = bus.tx_busy;
         model_step();
      end
   end

   // ---------------- helpers ----------------
   function automatic bit quiet();
      bit q;
      q = !bus.grant_valid && !bus.tx_busy && busy_left == 0;
      for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) q = 0;
      return q;
   endfunction

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!quiet() && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      check(name, 32'(quiet()), 32'd1);
   endtask

   task automatic clear_logs();
      glog.delete();
      txlog.delete();
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      sys_rst = 1'b1;
      @(posedge clk); #2;
      sys_rst = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin : tests
      int n;
      sys_rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("reset_grant_valid", 32'(bus.grant_valid), 32'd0);
      check("reset_grant_id",    32'(bus.grant_id),    32'd0);
      check("reset_tx_en",       32'(bus.tx_en),       32'd0);
      check("reset_tx_data",     32'(bus.tx_data),     32'd0);
      check("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
      check("reset_req_ready",   32'(bus.req_ready),   32'd0);
      @(posedge clk); #2;
      sys_rst = 1'b0;

      // 1: single requester, 3-byte packet
      clear_logs();
      lane_q[0].push_back({1'b0, 8'h55});
      lane_q[0].push_back({1'b0, 8'hAA});
      lane_q[0].push_back({1'b1, 8'h0F});
      wait_quiet("t1_done");
      check("t1_nbytes", 32'(txlog.size()), 32'd3);
      if (txlog.size() == 3) begin
         check("t1_byte0", 32'(txlog[0]), 32'h55);
         check("t1_byte1", 32'(txlog[1]), 32'hAA);
         check("t1_byte2", 32'(txlog[2]), 32'h0F);
      end
      check("t1_ngrants", 32'(glog.size()), 32'd1);
      if (glog.size() == 1) check("t1_grant", 32'(glog[0]), 32'd0);
      check("t1_gv_after_busy_fall", 32'(gv_fall_cyc - busy_fall_cyc), 32'd1);

      // 2: all four requesting continuously, single-byte packets
      pulse_reset();
      clear_logs();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) lane_q[i].push_back({1'b1, 8'(16*i + p)});
      wait_quiet("t2_done");
      check("t2_ngrants", 32'(glog.size()), 32'd8);
      if (glog.size() == 8) begin
         check("t2_g0", 32'(glog[0]), 32'd0);
         check("t2_g1", 32'(glog[1]), 32'd1);
         check("t2_g2", 32'(glog[2]), 32'd2);
         check("t2_g3", 32'(glog[3]), 32'd3);
         check("t2_g4", 32'(glog[4]), 32'd0);
         for (int k = 1; k < 8; k++) check("t2_no_repeat", 32'(glog[k] != glog[k-1]), 32'd1);
      end

      // 3: req2 arrives while req0 is mid-packet
      clear_logs();
      for (int b = 0; b < 4; b++) lane_q[0].push_back({b == 3, 8'hA0 + 8'(b)});
      n = 0;
      while (txlog.size() < 2 && n < 500) begin @(negedge clk); #1; n++; end
      check("t3_two_sent", 32'(txlog.size() >= 2), 32'd1);
      lane_q[2].push_back({1'b1, 8'hC0});
      wait_quiet("t3_done");
      check("t3_ngrants", 32'(glog.size()), 32'd2);
      if (glog.size() == 2) begin
         check("t3_first",  32'(glog[0]), 32'd0);
         check("t3_second", 32'(glog[1]), 32'd2);
      end
      check("t3_nbytes", 32'(txlog.size()), 32'd5);
      if (txlog.size() == 5) begin
         check("t3_last_of_req0", 32'(txlog[3]), 32'hA3);
         check("t3_req2_byte",    32'(txlog[4]), 32'hC0);
      end

      // 4: req1 stalls after a non-last byte -> timeout
      clear_logs();
      tmo_n = 0;
      lane_q[1].push_back({1'b0, 8'h11});
      n = 0;
      while (tmo_n == 0 && n < 500) begin @(negedge clk); #1; n++; end
      check("t4_timeout_seen", 32'(tmo_n), 32'd1);
      check("t4_timeout_delay", 32'(tmo_cyc - send_cyc), 32'd16);
      lane_q[1].push_back({1'b1, 8'h12});
      lane_q[3].push_back({1'b1, 8'h33});
      wait_quiet("t4_done");
      check("t4_ngrants", 32'(glog.size()), 32'd3);
      if (glog.size() == 3) begin
         check("t4_g0", 32'(glog[0]), 32'd1);
         check("t4_g1", 32'(glog[1]), 32'd3);
         check("t4_g2", 32'(glog[2]), 32'd1);
      end

      // 5: reset while WAIT_IDLE with tx_busy high
      clear_logs();
      lane_q[2].push_back({1'b0, 8'h21});
      lane_q[2].push_back({1'b1, 8'h22});
      n = 0;
      while (!bus.tx_busy && n < 200) begin @(negedge clk); #1; n++; end
      check("t5_busy_seen", 32'(bus.tx_busy), 32'd1);
      repeat (3) @(negedge clk);
      @(posedge clk); #2;
      sys_rst = 1'b1;
      lane_q[2].delete();
      lane_q[0].push_back({1'b1, 8'h0A});
      lane_q[3].push_back({1'b1, 8'h3A});
      clear_logs();
      @(posedge clk); #2;
      sys_rst = 1'b0;
      @(negedge clk); #1;
      check("t5_rst_tx_en",       32'(bus.tx_en),       32'd0);
      check("t5_rst_grant_valid", 32'(bus.grant_valid), 32'd0);
      check("t5_busy_still_high", 32'(bus.tx_busy),     32'd1);
      n = 0;
      while (bus.tx_busy && n < 200) begin @(negedge clk); #1; n++; end
      check("t5_busy_fell", 32'(bus.tx_busy), 32'd0);
      check("t5_no_grant_while_busy", 32'(glog.size()), 32'd0);
      wait_quiet("t5_done");
      check("t5_ngrants", 32'(glog.size()), 32'd2);
      if (glog.size() == 2) begin
         check("t5_g0", 32'(glog[0]), 32'd0);
         check("t5_g1", 32'(glog[1]), 32'd3);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
